memory_access_stage: RTL and testbench
======================================

Name: memory_access_stage

Overview:
- Pipeline stage directly upstream of the write-back stage.
- Takes execute-stage results and performs load/store accesses to the data cache over a valid/ready request and response handshake.
- Aligns and sign/zero-extends load data, then registers everything the write-back stage consumes: RD address, ALU result, load data, mux select and write enable.
- Stalls upstream while a cache access is outstanding.

Parameters:
- DATA_W, 32, data path width; only 32 is supported.
- ADDR_W, 32, byte address width.

Ports:
- CLK  in  1  clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- VALID_IN  in  1  execute stage presents an instruction.
- RD_ADDRESS_IN  in  5  destination register.
- ALU_OUT_IN  in  32  ALU result; byte address for loads and stores.
- RS2_DATA_IN  in  32  store data.
- MEM_READ_IN  in  1  load.
- MEM_WRITE_IN  in  1  store.
- MEM_SIZE_IN  in  3  funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU).
- WRITE_BACK_MUX_SELECT_IN  in  1  1 selects load data in write-back.
- RD_WRITE_ENABLE_IN  in  1  register-file write request.
- STALL_OUT  out  1  upstream must hold its outputs.
- DC_REQ_VALID  out  1  cache request valid.
- DC_REQ_READY  in  1  cache accepts request.
- DC_ADDR  out  32  word-aligned address ({addr[31:2],2'b00}).
- DC_WE  out  1  store request.
- DC_BYTE_EN  out  4  byte lanes.
- DC_WDATA  out  32  lane-replicated store data.
- DC_RESP_VALID  in  1  load data valid.
- DC_RDATA  in  32  raw load word.
- RD_ADDRESS_OUT  out  5  to write-back.
- ALU_OUT_OUT  out  32  to write-back.
- DATA_CACHE_OUT_DATA  out  32  extended load data to write-back.
- WRITE_BACK_MUX_SELECT_OUT  out  1  to write-back.
- RD_WRITE_ENABLE_OUT  out  1  to write-back; qualified with valid.
- MISALIGNED_OUT  out  1  one-cycle misalignment pulse (only with the optional feature).

Behaviour:
- Reset (async, RST_N=0): state IDLE; all outputs 0, including STALL_OUT and DC_REQ_VALID. Reset mid-access abandons the access; a late DC_RESP_VALID after reset is ignored while in IDLE.
- Accept condition: VALID_IN && !STALL_OUT. STALL_OUT = (state != IDLE), registered.
- FSM states: IDLE, REQ, WAIT.
- IDLE, non-memory op accepted: next cycle the *_OUT registers carry the inputs, and RD_WRITE_ENABLE_OUT = RD_WRITE_ENABLE_IN. Latency 1, no stall.
- IDLE, load or store accepted: fields captured into internal registers; go to REQ. The *_OUT registers present a bubble (RD_WRITE_ENABLE_OUT=0) every cycle until completion.
- IDLE, VALID_IN=0: bubble.
- REQ: DC_REQ_VALID=1; DC_ADDR, DC_WE, DC_BYTE_EN and DC_WDATA are stable until DC_REQ_READY. On handshake, a store returns to IDLE and emits a bubble; a load goes to WAIT.
- WAIT: on DC_RESP_VALID, register the extended data, ALU_OUT, RD, select and enable into the outputs, then return to IDLE. DC_RESP_VALID is ignored in IDLE and REQ.
- Byte enables: B = 0001<<addr[1:0]; H = 0011<<{addr[1],0}; W = 1111. Loads drive the same pattern.
- Store data: SB replicates byte[7:0] x4; SH replicates half[15:0] x2; SW unchanged.
- Load extension: B/BU select the byte at addr[1:0], then sign- or zero-extend; H/HU select the half at addr[1], then extend; W passes through.
- MEM_READ_IN and MEM_WRITE_IN both 1: treated as a store.
- Reserved funct3 values (011, 110, 111): treated as W.

Optional Feature:
- Macro: MEM_STAGE_MISALIGN_CHECK_EN.
- Defined: an H access with addr[0]=1, or a W access with addr[1:0]!=0, issues no cache request. The stage stays in IDLE, the next cycle outputs a bubble, and MISALIGNED_OUT pulses 1 for that cycle.
- Undefined: no check is made; lanes are computed as above, so low address bits are effectively truncated. MISALIGNED_OUT is tied to 0.

Decomposition:
- Shared package: funct3 size constants, the state enum (IDLE/REQ/WAIT) and the byte-enable width.
- Sub-module load_data_aligner: purely combinational lane select and sign/zero extension, from addr[1:0], size and raw word to 32-bit data.

Test Plan:
- Non-memory op, ALU_OUT_IN=0x0000_1234, RD=5, enable=1 -> next cycle ALU_OUT_OUT=0x1234, RD_ADDRESS_OUT=5, RD_WRITE_ENABLE_OUT=1, STALL_OUT=0.
- LB at addr 0x103, DC_REQ_READY delayed 2 cycles, response 0x80FF_FF00 -> DC_BYTE_EN=1000 and DC_ADDR=0x100 held stable; DATA_CACHE_OUT_DATA=0xFFFF_FF80; STALL_OUT high from the cycle after accept until the completion cycle.
- LHU at addr 0x102, response 0x9ABC_0000 -> DATA_CACHE_OUT_DATA=0x0000_9ABC.
- SH at addr 0x2, RS2=0x1234_5678 -> DC_WE=1, DC_BYTE_EN=1100, DC_WDATA=0x5678_5678; output is a bubble; back in IDLE after the handshake.
- RST_N low while in WAIT, then a late DC_RESP_VALID -> all outputs 0, state IDLE, response ignored, no write enable.
- With MEM_STAGE_MISALIGN_CHECK_EN, LW at addr 0x101 -> DC_REQ_VALID stays 0, MISALIGNED_OUT=1 for one cycle, RD_WRITE_ENABLE_OUT=0.

Source files
------------

// File: rtl/memory_access_stage_pkg.sv
// Shared definitions for the memory access stage: funct3 size codes,
// the access FSM state type, the byte-enable width and a lane helper.
package memory_access_stage_pkg;

   localparam int BYTE_EN_W = 4;

   localparam logic [2:0] FUNCT3_B  = 3'b000;
   localparam logic [2:0] FUNCT3_H  = 3'b001;
   localparam logic [2:0] FUNCT3_W  = 3'b010;
   localparam logic [2:0] FUNCT3_BU = 3'b100;
   localparam logic [2:0] FUNCT3_HU = 3'b101;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2
   } stage_state_t;

   // Byte lanes touched by an access; size[1:0] alone decides the width,
   // and every code that is not a byte or half (including the reserved
   // ones) is handled as a full word.
   function automatic logic [BYTE_EN_W-1:0] calc_byte_en(input logic [2:0] size,
                                                         input logic [1:0] addr_lo);
      logic [BYTE_EN_W-1:0] lanes;
      case (size[1:0])
         2'b00:   lanes = 4'b0001 << addr_lo;
         2'b01:   lanes = 4'b0011 << {addr_lo[1], 1'b0};
         default: lanes = 4'b1111;
      endcase
      return lanes;
   endfunction

endpackage

// File: rtl/memory_access_stage_load_data_aligner.sv
// Combinational load lane select and sign/zero extension.
module load_data_aligner
   import memory_access_stage_pkg::*;
(
   input  logic [1:0]  addr_lo,
   input  logic [2:0]  size,
   input  logic [31:0] raw_data,
   output logic [31:0] load_data
);

   logic [7:0]  sel_byte;
   logic [15:0] sel_half;

   // Pick the addressed byte or half and extend; size[2] set means unsigned.
   always_comb begin
      sel_byte  = 8'h00;
      sel_half  = 16'h0000;
      load_data = raw_data;
      case (size[1:0])
         2'b00: begin
            case (addr_lo)
               2'd0:    sel_byte = raw_data[7:0];
               2'd1:    sel_byte = raw_data[15:8];
               2'd2:    sel_byte = raw_data[23:16];
               default: sel_byte = raw_data[31:24];
            endcase
            load_data = size[2] ? {24'h000000, sel_byte}
                                : {{24{sel_byte[7]}}, sel_byte};
         end
         2'b01: begin
            sel_half  = addr_lo[1] ? raw_data[31:16] : raw_data[15:0];
            load_data = size[2] ? {16'h0000, sel_half}
                                : {{16{sel_half[15]}}, sel_half};
         end
         default: load_data = raw_data;
      endcase
   end

endmodule

// File: rtl/memory_access_stage.sv
// Memory access stage: issues loads/stores to the data cache over a
// valid/ready handshake, stalls upstream while an access is in flight,
// and registers the write-back fields.
// Optional build macro MEM_STAGE_MISALIGN_CHECK_EN drops misaligned H/W
// accesses and pulses misaligned_out instead of issuing a request.
module memory_access_stage
   import memory_access_stage_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 valid_in,
   input  logic [4:0]           rd_address_in,
   input  logic [DATA_W-1:0]    alu_out_in,
   input  logic [DATA_W-1:0]    rs2_data_in,
   input  logic                 mem_read_in,
   input  logic                 mem_write_in,
   input  logic [2:0]           mem_size_in,
   input  logic                 write_back_mux_select_in,
   input  logic                 rd_write_enable_in,
   output logic                 stall_out,
   output logic                 dc_req_valid,
   input  logic                 dc_req_ready,
   output logic [ADDR_W-1:0]    dc_addr,
   output logic                 dc_we,
   output logic [BYTE_EN_W-1:0] dc_byte_en,
   output logic [DATA_W-1:0]    dc_wdata,
   input  logic                 dc_resp_valid,
   input  logic [DATA_W-1:0]    dc_rdata,
   output logic [4:0]           rd_address_out,
   output logic [DATA_W-1:0]    alu_out_out,
   output logic [DATA_W-1:0]    data_cache_out_data,
   output logic                 write_back_mux_select_out,
   output logic                 rd_write_enable_out,
   output logic                 misaligned_out
);

   stage_state_t state, next_state;

   logic                 accept;
   logic                 is_mem;
   logic                 misalign_hit;
   logic                 start_access;
   logic [DATA_W-1:0]    store_data;
   logic [DATA_W-1:0]    aligned_load;

   logic [DATA_W-1:0]    cap_alu;
   logic [4:0]           cap_rd;
   logic                 cap_we;
   logic [2:0]           cap_size;
   logic [BYTE_EN_W-1:0] cap_be;
   logic [DATA_W-1:0]    cap_wdata;
   logic                 cap_sel;
   logic                 cap_wen;

   assign stall_out    = (state != IDLE);
   assign accept       = valid_in && !stall_out;
   assign is_mem       = mem_read_in || mem_write_in;
   assign start_access = accept && is_mem && !misalign_hit;

`ifdef MEM_STAGE_MISALIGN_CHECK_EN
   logic misaligned_q;

   assign misalign_hit = ((mem_size_in[1:0] == 2'b01) && alu_out_in[0]) ||
                         (mem_size_in[1] && (alu_out_in[1:0] != 2'b00));
   assign misaligned_out = misaligned_q;

   // One-cycle flag for a dropped misaligned access.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) misaligned_q <= 1'b0;
      else        misaligned_q <= accept && is_mem && misalign_hit;
   end
`else
   assign misalign_hit   = 1'b0;
   assign misaligned_out = 1'b0;
`endif

   // Replicate store data across lanes so the cache only has to honour byte enables.
   always_comb begin
      case (mem_size_in[1:0])
         2'b00:   store_data = {4{rs2_data_in[7:0]}};
         2'b01:   store_data = {2{rs2_data_in[15:0]}};
         default: store_data = rs2_data_in;
      endcase
   end

   load_data_aligner u_aligner (
      .addr_lo   (cap_alu[1:0]),
      .size      (cap_size),
      .raw_data  (dc_rdata),
      .load_data (aligned_load)
   );

   // Access FSM state register; reset abandons any outstanding access.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= next_state;
   end

   // Next-state logic; a request leaves REQ only on the ready handshake.
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (start_access) next_state = REQ;
         REQ:     if (dc_req_ready) next_state = cap_we ? IDLE : WAIT;
         WAIT:    if (dc_resp_valid) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Capture the memory op so the request stays stable while upstream is stalled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cap_alu   <= '0;
         cap_rd    <= '0;
         cap_we    <= 1'b0;
         cap_size  <= '0;
         cap_be    <= '0;
         cap_wdata <= '0;
         cap_sel   <= 1'b0;
         cap_wen   <= 1'b0;
      end else if (state == IDLE && start_access) begin
         cap_alu   <= alu_out_in;
         cap_rd    <= rd_address_in;
         cap_we    <= mem_write_in;
         cap_size  <= mem_size_in;
         cap_be    <= calc_byte_en(mem_size_in, alu_out_in[1:0]);
         cap_wdata <= store_data;
         cap_sel   <= write_back_mux_select_in;
         cap_wen   <= rd_write_enable_in;
      end
   end

   assign dc_req_valid = (state == REQ);
   assign dc_addr      = dc_req_valid ? {cap_alu[ADDR_W-1:2], 2'b00} : '0;
   assign dc_we        = dc_req_valid && cap_we;
   assign dc_byte_en   = dc_req_valid ? cap_be : '0;
   assign dc_wdata     = (dc_req_valid && cap_we) ? cap_wdata : '0;

   // Write-back registers: a bubble every cycle unless a non-memory op
   // passes straight through or a load response completes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_address_out            <= '0;
         alu_out_out               <= '0;
         data_cache_out_data       <= '0;
         write_back_mux_select_out <= 1'b0;
         rd_write_enable_out       <= 1'b0;
      end else begin
         rd_address_out            <= '0;
         alu_out_out               <= '0;
         data_cache_out_data       <= '0;
         write_back_mux_select_out <= 1'b0;
         rd_write_enable_out       <= 1'b0;
         if (state == IDLE && accept && !is_mem) begin
            rd_address_out            <= rd_address_in;
            alu_out_out               <= alu_out_in;
            write_back_mux_select_out <= write_back_mux_select_in;
            rd_write_enable_out       <= rd_write_enable_in;
         end else if (state == WAIT && dc_resp_valid) begin
            rd_address_out            <= cap_rd;
            alu_out_out               <= cap_alu;
            data_cache_out_data       <= aligned_load;
            write_back_mux_select_out <= cap_sel;
            rd_write_enable_out       <= cap_wen;
         end
      end
   end

endmodule

// File: tb/tb_memory_access_stage.sv
// Directed testbench for memory_access_stage with hand-computed expectations.
module tb_memory_access_stage;

   logic        clk;
   logic        rst_n;
   logic        valid_in;
   logic [4:0]  rd_address_in;
   logic [31:0] alu_out_in;
   logic [31:0] rs2_data_in;
   logic        mem_read_in;
   logic        mem_write_in;
   logic [2:0]  mem_size_in;
   logic        write_back_mux_select_in;
   logic        rd_write_enable_in;
   logic        stall_out;
   logic        dc_req_valid;
   logic        dc_req_ready;
   logic [31:0] dc_addr;
   logic        dc_we;
   logic [3:0]  dc_byte_en;
   logic [31:0] dc_wdata;
   logic        dc_resp_valid;
   logic [31:0] dc_rdata;
   logic [4:0]  rd_address_out;
   logic [31:0] alu_out_out;
   logic [31:0] data_cache_out_data;
   logic        write_back_mux_select_out;
   logic        rd_write_enable_out;
   logic        misaligned_out;

   int testCount = 0;
   int failCount = 0;

   memory_access_stage dut (
      .clk                       (clk),
      .rst_n                     (rst_n),
      .valid_in                  (valid_in),
      .rd_address_in             (rd_address_in),
      .alu_out_in                (alu_out_in),
      .rs2_data_in               (rs2_data_in),
      .mem_read_in               (mem_read_in),
      .mem_write_in              (mem_write_in),
      .mem_size_in               (mem_size_in),
      .write_back_mux_select_in  (write_back_mux_select_in),
      .rd_write_enable_in        (rd_write_enable_in),
      .stall_out                 (stall_out),
      .dc_req_valid              (dc_req_valid),
      .dc_req_ready              (dc_req_ready),
      .dc_addr                   (dc_addr),
      .dc_we                     (dc_we),
      .dc_byte_en                (dc_byte_en),
      .dc_wdata                  (dc_wdata),
      .dc_resp_valid             (dc_resp_valid),
      .dc_rdata                  (dc_rdata),
      .rd_address_out            (rd_address_out),
      .alu_out_out               (alu_out_out),
      .data_cache_out_data       (data_cache_out_data),
      .write_back_mux_select_out (write_back_mux_select_out),
      .rd_write_enable_out       (rd_write_enable_out),
      .misaligned_out            (misaligned_out)
   );

   // 10 ns clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      testCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic v, input logic [4:0] rd, input logic [31:0] alu,
                                input logic [31:0] rs2, input logic rdEn, input logic wrEn,
                                input logic [2:0] size, input logic sel, input logic wen);
      valid_in                 = v;
      rd_address_in            = rd;
      alu_out_in               = alu;
      rs2_data_in              = rs2;
      mem_read_in              = rdEn;
      mem_write_in             = wrEn;
      mem_size_in              = size;
      write_back_mux_select_in = sel;
      rd_write_enable_in       = wen;
   endtask

   task automatic idleInputs();
      applyStimulus(1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0);
   endtask

   // Inputs are driven and outputs sampled on the falling edge.
   task automatic nextCycle();
      @(negedge clk);
   endtask

   initial begin
      rst_n         = 1'b0;
      dc_req_ready  = 1'b0;
      dc_resp_valid = 1'b0;
      dc_rdata      = 32'h0;
      idleInputs();
      nextCycle();
      nextCycle();
      checkOutput("reset_stall", {31'b0, stall_out}, 32'h0);
      checkOutput("reset_req_valid", {31'b0, dc_req_valid}, 32'h0);
      checkOutput("reset_wen", {31'b0, rd_write_enable_out}, 32'h0);
      checkOutput("reset_alu_out", alu_out_out, 32'h0);
      rst_n = 1'b1;
      nextCycle();

      // Non-memory op passes through with latency 1
      applyStimulus(1'b1, 5'd5, 32'h0000_1234, 32'h0, 1'b0, 1'b0, 3'b010, 1'b0, 1'b1);
      nextCycle();
      idleInputs();
      checkOutput("alu_alu_out", alu_out_out, 32'h0000_1234);
      checkOutput("alu_rd", {27'b0, rd_address_out}, 32'd5);
      checkOutput("alu_wen", {31'b0, rd_write_enable_out}, 32'h1);
      checkOutput("alu_stall", {31'b0, stall_out}, 32'h0);
      nextCycle();
      checkOutput("idle_bubble_wen", {31'b0, rd_write_enable_out}, 32'h0);

      // LB at 0x103, ready delayed two cycles, response 0x80FF_FF00
      applyStimulus(1'b1, 5'd7, 32'h0000_0103, 32'h0, 1'b1, 1'b0, 3'b000, 1'b1, 1'b1);
      nextCycle();
      idleInputs();
      checkOutput("lb_stall", {31'b0, stall_out}, 32'h1);
      checkOutput("lb_req_valid", {31'b0, dc_req_valid}, 32'h1);
      checkOutput("lb_byte_en", {28'b0, dc_byte_en}, 32'h8);
      checkOutput("lb_addr", dc_addr, 32'h0000_0100);
      checkOutput("lb_we", {31'b0, dc_we}, 32'h0);
      checkOutput("lb_bubble_wen", {31'b0, rd_write_enable_out}, 32'h0);
      nextCycle();
      checkOutput("lb_byte_en_held", {28'b0, dc_byte_en}, 32'h8);
      checkOutput("lb_addr_held", dc_addr, 32'h0000_0100);
      checkOutput("lb_stall_held", {31'b0, stall_out}, 32'h1);
      dc_req_ready = 1'b1;
      nextCycle();
      dc_req_ready = 1'b0;
      checkOutput("lb_wait_req_valid", {31'b0, dc_req_valid}, 32'h0);
      checkOutput("lb_wait_stall", {31'b0, stall_out}, 32'h1);
      dc_resp_valid = 1'b1;
      dc_rdata      = 32'h80FF_FF00;
      nextCycle();
      dc_resp_valid = 1'b0;
      checkOutput("lb_data", data_cache_out_data, 32'hFFFF_FF80);
      checkOutput("lb_wen", {31'b0, rd_write_enable_out}, 32'h1);
      checkOutput("lb_rd", {27'b0, rd_address_out}, 32'd7);
      checkOutput("lb_sel", {31'b0, write_back_mux_select_out}, 32'h1);
      checkOutput("lb_done_stall", {31'b0, stall_out}, 32'h0);

      // LHU at 0x102, response 0x9ABC_0000
      applyStimulus(1'b1, 5'd9, 32'h0000_0102, 32'h0, 1'b1, 1'b0, 3'b101, 1'b1, 1'b1);
      nextCycle();
      idleInputs();
      checkOutput("lhu_byte_en", {28'b0, dc_byte_en}, 32'hC);
      dc_req_ready = 1'b1;
      nextCycle();
      dc_req_ready  = 1'b0;
      dc_resp_valid = 1'b1;
      dc_rdata      = 32'h9ABC_0000;
      nextCycle();
      dc_resp_valid = 1'b0;
      checkOutput("lhu_data", data_cache_out_data, 32'h0000_9ABC);
      checkOutput("lhu_alu_out", alu_out_out, 32'h0000_0102);

      // LH at 0x0, response 0x0000_8001 sign-extends
      applyStimulus(1'b1, 5'd3, 32'h0000_0000, 32'h0, 1'b1, 1'b0, 3'b001, 1'b1, 1'b1);
      nextCycle();
      idleInputs();
      checkOutput("lh_byte_en", {28'b0, dc_byte_en}, 32'h3);
      dc_req_ready = 1'b1;
      nextCycle();
      dc_req_ready  = 1'b0;
      dc_resp_valid = 1'b1;
      dc_rdata      = 32'h0000_8001;
      nextCycle();
      dc_resp_valid = 1'b0;
      checkOutput("lh_data", data_cache_out_data, 32'hFFFF_8001);

      // SH at 0x2, RS2 0x1234_5678
      applyStimulus(1'b1, 5'd4, 32'h0000_0002, 32'h1234_5678, 1'b0, 1'b1, 3'b001, 1'b0, 1'b0);
      nextCycle();
      idleInputs();
      checkOutput("sh_we", {31'b0, dc_we}, 32'h1);
      checkOutput("sh_byte_en", {28'b0, dc_byte_en}, 32'hC);
      checkOutput("sh_wdata", dc_wdata, 32'h5678_5678);
      checkOutput("sh_addr", dc_addr, 32'h0000_0000);
      checkOutput("sh_bubble_wen", {31'b0, rd_write_enable_out}, 32'h0);
      dc_req_ready = 1'b1;
      nextCycle();
      dc_req_ready = 1'b0;
      checkOutput("sh_done_stall", {31'b0, stall_out}, 32'h0);
      checkOutput("sh_done_req_valid", {31'b0, dc_req_valid}, 32'h0);
      checkOutput("sh_done_wen", {31'b0, rd_write_enable_out}, 32'h0);

      // SB with both read and write set acts as a store, replicated byte
      applyStimulus(1'b1, 5'd6, 32'h0000_0011, 32'hAABB_CCDD, 1'b1, 1'b1, 3'b000, 1'b1, 1'b1);
      nextCycle();
      idleInputs();
      checkOutput("sb_we", {31'b0, dc_we}, 32'h1);
      checkOutput("sb_byte_en", {28'b0, dc_byte_en}, 32'h2);
      checkOutput("sb_wdata", dc_wdata, 32'hDDDD_DDDD);
      dc_req_ready = 1'b1;
      nextCycle();
      dc_req_ready = 1'b0;
      checkOutput("sb_done_stall", {31'b0, stall_out}, 32'h0);

      // Reset while waiting for a load response, then a late response
      applyStimulus(1'b1, 5'd8, 32'h0000_0200, 32'h0, 1'b1, 1'b0, 3'b010, 1'b1, 1'b1);
      nextCycle();
      idleInputs();
      dc_req_ready = 1'b1;
      nextCycle();
      dc_req_ready = 1'b0;
      checkOutput("rst_pre_stall", {31'b0, stall_out}, 32'h1);
      rst_n = 1'b0;
      #1;
      checkOutput("rst_mid_stall", {31'b0, stall_out}, 32'h0);
      checkOutput("rst_mid_req_valid", {31'b0, dc_req_valid}, 32'h0);
      nextCycle();
      rst_n = 1'b1;
      dc_resp_valid = 1'b1;
      dc_rdata      = 32'hDEAD_BEEF;
      nextCycle();
      dc_resp_valid = 1'b0;
      checkOutput("rst_late_wen", {31'b0, rd_write_enable_out}, 32'h0);
      checkOutput("rst_late_data", data_cache_out_data, 32'h0);
      checkOutput("rst_late_stall", {31'b0, stall_out}, 32'h0);

`ifdef MEM_STAGE_MISALIGN_CHECK_EN
      // Misaligned LW is dropped with a one-cycle flag
      applyStimulus(1'b1, 5'd10, 32'h0000_0101, 32'h0, 1'b1, 1'b0, 3'b010, 1'b1, 1'b1);
      nextCycle();
      idleInputs();
      checkOutput("mis_req_valid", {31'b0, dc_req_valid}, 32'h0);
      checkOutput("mis_flag", {31'b0, misaligned_out}, 32'h1);
      checkOutput("mis_wen", {31'b0, rd_write_enable_out}, 32'h0);
      checkOutput("mis_stall", {31'b0, stall_out}, 32'h0);
      nextCycle();
      checkOutput("mis_flag_clear", {31'b0, misaligned_out}, 32'h0);
`else
      // Without the check a misaligned LW is issued with address truncated
      applyStimulus(1'b1, 5'd10, 32'h0000_0101, 32'h0, 1'b1, 1'b0, 3'b010, 1'b1, 1'b1);
      nextCycle();
      idleInputs();
      checkOutput("lw_trunc_req_valid", {31'b0, dc_req_valid}, 32'h1);
      checkOutput("lw_trunc_addr", dc_addr, 32'h0000_0100);
      checkOutput("lw_trunc_byte_en", {28'b0, dc_byte_en}, 32'hF);
      checkOutput("lw_trunc_flag", {31'b0, misaligned_out}, 32'h0);
      dc_req_ready = 1'b1;
      nextCycle();
      dc_req_ready  = 1'b0;
      dc_resp_valid = 1'b1;
      dc_rdata      = 32'hCAFE_F00D;
      nextCycle();
      dc_resp_valid = 1'b0;
      checkOutput("lw_trunc_data", data_cache_out_data, 32'hCAFE_F00D);
`endif

      nextCycle();
      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
